approx_rc_adder_pipe: RTL and testbench

- Parametrised, 2-stage pipelined successor to the fixed 16-bit approximate ripple-carry adders.
- Approximation depth and cell type are selectable per transaction. An exact reference sum is computed in parallel.
- Signed error is output per result, and running error statistics are kept on chip.
- Sits between a stimulus source and a scoreboard in the approximate-adder characterisation flow. Valid/ready on both sides.

---
 rtl/approx_rc_adder_pipe_if.sv | 23 ++
 rtl/approx_rc_adder_pipe.sv | 118 +++++++++++
 tb/tb_approx_rc_adder_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_rc_adder_pipe_if.sv
// Request (operands + per-beat config) and response (sums + error) channels
// of the pipelined approximate ripple-carry adder.
interface approx_rc_adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int KW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [KW-1:0]    cfg_k;
    logic [1:0]       cfg_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [WIDTH:0]   out_exact;
    logic [WIDTH+1:0] out_err;

    modport master (output in_valid, in_a, in_b, cfg_k, cfg_mode, out_ready,
                    input  in_ready, out_valid, out_sum, out_exact, out_err);
    modport slave  (input  in_valid, in_a, in_b, cfg_k, cfg_mode, out_ready,
                    output in_ready, out_valid, out_sum, out_exact, out_err);
endinterface

// File: rtl/approx_rc_adder_pipe.sv
// 2-stage approximate ripple-carry adder with per-beat approximation depth and
// cell type, parallel exact sum, signed error output and running error stats.
module approx_rc_adder_pipe #(
    parameter int WIDTH      = 16,
    parameter int APPROX_MAX = 14,
    parameter int KW         = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    approx_rc_adder_pipe_if.slave bus,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      stat_n,
    output logic [CNT_W-1:0]      stat_nerr,
    output logic [WIDTH:0]        stat_maxabs,
    output logic [CNT_W-1:0]      stat_sumabs
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [WIDTH:0] sum;
        logic [WIDTH:0] exact;
    } s1_t;

    logic [KW-1:0]     keff;
    logic [WIDTH:0]    approx_sum;
    logic [STAGES:1]   vld_pipe;
    s1_t               s1;
    logic [WIDTH:0]    sum_q;
    logic [WIDTH:0]    exact_q;
    logic [WIDTH+1:0]  err_q;
    logic              s1_adv;
    logic              s2_adv;
    logic              accept;
    logic              hs;
    logic [WIDTH:0]    abs_err;
    logic [CNT_W:0]    sumabs_nxt;

    assign keff = (bus.cfg_k > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : bus.cfg_k;

    // Single scalar carry walks the chain so the ripple stays acyclic.
    always_comb begin : p_approx
        logic c, s, co, x, y;
        c          = 1'b0;
        approx_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            x  = bus.in_a[i];
            y  = bus.in_b[i];
            s  = x ^ y ^ c;
            co = (x & y) | (c & (x ^ y));
            if ((i < APPROX_MAX) && (KW'(i) < keff)) begin
                case (bus.cfg_mode)
                    2'd1:    begin s = ~c;    co = 1'b0; end
                    2'd2:    begin s = x | y; co = 1'b0; end
                    default: ;
                endcase
            end
            approx_sum[i] = s;
            c             = co;
        end
        approx_sum[WIDTH] = c;
    end

    assign s2_adv       = !vld_pipe[2] || bus.out_ready;
    assign s1_adv       = vld_pipe[1] && s2_adv;
    assign bus.in_ready = !vld_pipe[1] || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign hs           = vld_pipe[2] && bus.out_ready;

    assign bus.out_valid = vld_pipe[2];
    assign bus.out_sum   = sum_q;
    assign bus.out_exact = exact_q;
    assign bus.out_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            sum_q    <= '0;
            exact_q  <= '0;
            err_q    <= '0;
        end else begin
            if (accept) begin
                vld_pipe[1] <= 1'b1;
                s1.sum      <= approx_sum;
                s1.exact    <= {1'b0, bus.in_a} + {1'b0, bus.in_b};
            end else if (s1_adv) begin
                vld_pipe[1] <= 1'b0;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    sum_q   <= s1.sum;
                    exact_q <= s1.exact;
                    err_q   <= {1'b0, s1.sum} - {1'b0, s1.exact};
                end
            end
        end
    end

    // Magnitude straight from the unsigned operands avoids negating err_q.
    assign abs_err    = (sum_q >= exact_q) ? (sum_q - exact_q) : (exact_q - sum_q);
    assign sumabs_nxt = {1'b0, stat_sumabs} + (CNT_W+1)'(abs_err);

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_n      <= '0;
            stat_nerr   <= '0;
            stat_maxabs <= '0;
            stat_sumabs <= '0;
        end else if (hs) begin
            stat_n <= stat_n + 1'b1;
            if (sum_q != exact_q) stat_nerr <= stat_nerr + 1'b1;
            if (abs_err > stat_maxabs) stat_maxabs <= abs_err;
            stat_sumabs <= sumabs_nxt[CNT_W] ? '1 : sumabs_nxt[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Bench for approx_rc_adder_pipe: directed spec vectors plus randomized
// streams against an arithmetic reference model and stats model.
module tb_approx_rc_adder_pipe;
    localparam int W    = 16;
    localparam int AMAX = 14;
    localparam int KW   = 5;
    localparam int CW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stat_clr = 1'b0;
    logic [CW-1:0] stat_n, stat_nerr, stat_sumabs;
    logic [W:0]    stat_maxabs;

    int checks = 0;
    int errors = 0;
    longint exp_n = 0, exp_nerr = 0, exp_maxabs = 0, exp_sumabs = 0;

    approx_rc_adder_pipe_if #(.WIDTH(W), .KW(KW)) bus ();

    approx_rc_adder_pipe #(.WIDTH(W), .APPROX_MAX(AMAX), .KW(KW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stat_clr(stat_clr),
        .stat_n(stat_n), .stat_nerr(stat_nerr),
        .stat_maxabs(stat_maxabs), .stat_sumabs(stat_sumabs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0]   s;
        logic [W:0]   e;
        logic [W+1:0] er;
        longint       err;
    } exp_t;

    // Low keff bits: all ones (mode 1) or a|b (mode 2); high part adds exactly
    // with no carry coming in from below.
    function automatic longint ref_sum(longint a, longint b, int k, int mode);
        int ke = (k > AMAX) ? AMAX : k;
        longint one = 1;
        longint msk, lo, hi;
        if ((mode == 1 || mode == 2) && ke > 0) begin
            msk = (one << ke) - 1;
            lo  = (mode == 1) ? msk : ((a | b) & msk);
            hi  = ((a >> ke) + (b >> ke)) << ke;
            return hi | lo;
        end
        return a + b;
    endfunction

    task automatic model_stat(input longint e);
        longint ab = (e < 0) ? -e : e;
        exp_n++;
        if (e != 0) exp_nerr++;
        if (ab > exp_maxabs) exp_maxabs = ab;
        exp_sumabs += ab;
        if (exp_sumabs > 64'hFFFF_FFFF) exp_sumabs = 64'hFFFF_FFFF;
    endtask

    task automatic model_clr();
        exp_n = 0; exp_nerr = 0; exp_maxabs = 0; exp_sumabs = 0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int k, input int mode, output bit ok);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        bus.cfg_k = KW'(k); bus.cfg_mode = 2'(mode);
        #1;
        while (!bus.in_ready && t < 20) begin @(negedge clk); #1; t++; end
        ok = bus.in_ready;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic recv(output bit ok, output logic [W:0] s, output logic [W:0] e,
                        output logic [W+1:0] er);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
        ok = bus.out_valid; s = bus.out_sum; e = bus.out_exact; er = bus.out_err;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.out_exact !== '0 || bus.out_err !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b s=%h e=%h er=%h want all 0",
                     bus.out_valid, bus.out_sum, bus.out_exact, bus.out_err);
        end
        checks++;
        if (stat_n !== '0 || stat_nerr !== '0 || stat_maxabs !== '0 || stat_sumabs !== '0) begin
            errors++;
            $display("FAIL reset_stats got n=%0d nerr=%0d max=%0d sum=%0d want 0",
                     stat_n, stat_nerr, stat_maxabs, stat_sumabs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_mode1();
        bit ok, ok2;
        logic [W:0] s, e; logic [W+1:0] er;
        bus.out_ready = 1'b1;
        send(16'h0003, 16'h0001, 14, 1, ok);
        recv(ok2, s, e, er);
        checks++;
        if (!(ok && ok2)) begin errors++; $display("FAIL mode1_a timeout got %b%b want 11", ok, ok2); end
        checks++;
        if (s !== 17'h03FFF || e !== 17'h00004 || er !== 18'd16379) begin
            errors++; $display("FAIL mode1_a got s=%h e=%h er=%h want 03fff 00004 %h", s, e, er, 18'd16379);
        end
        model_stat(16379);
        @(negedge clk);
        checks++;
        if (stat_nerr !== CW'(exp_nerr) || stat_n !== CW'(exp_n)) begin
            errors++; $display("FAIL mode1_a_stats got n=%0d nerr=%0d want %0d %0d", stat_n, stat_nerr, exp_n, exp_nerr);
        end
        send(16'hFFFF, 16'h0001, 14, 1, ok);
        recv(ok2, s, e, er);
        checks++;
        if (!(ok && ok2) || s !== 17'h0FFFF || e !== 17'h10000 || er !== 18'h3FFFF) begin
            errors++; $display("FAIL mode1_b got ok=%b%b s=%h e=%h er=%h want 0ffff 10000 3ffff", ok, ok2, s, e, er);
        end
        model_stat(-1);
        @(negedge clk);
        checks++;
        if (stat_maxabs !== 17'd16379 || stat_sumabs !== CW'(exp_sumabs) || stat_nerr !== CW'(exp_nerr)) begin
            errors++; $display("FAIL mode1_b_stats got max=%0d sum=%0d nerr=%0d want 16379 %0d %0d",
                               stat_maxabs, stat_sumabs, stat_nerr, exp_sumabs, exp_nerr);
        end
    endtask

    task automatic test_mode2_and_exact();
        int ks[3]       = '{4, 0, 4};
        int ms[3]       = '{2, 2, 3};
        logic [W:0] xs[3]   = '{17'h0000F, 17'h00010, 17'h00010};
        logic [W+1:0] xe[3] = '{18'h3FFFF, 18'h0, 18'h0};
        bit ok, ok2;
        logic [W:0] s, e; logic [W+1:0] er;
        for (int i = 0; i < 3; i++) begin
            send(16'h000F, 16'h0001, ks[i], ms[i], ok);
            recv(ok2, s, e, er);
            checks++;
            if (!(ok && ok2) || s !== xs[i] || er !== xe[i] || e !== 17'h00010) begin
                errors++; $display("FAIL mode2_case%0d got ok=%b%b s=%h e=%h er=%h want %h 00010 %h",
                                   i, ok, ok2, s, e, er, xs[i], xe[i]);
            end
            model_stat((i == 0) ? -1 : 0);
        end
        @(negedge clk);
        checks++;
        if (stat_n !== CW'(exp_n) || stat_nerr !== CW'(exp_nerr)) begin
            errors++; $display("FAIL mode2_stats got n=%0d nerr=%0d want %0d %0d", stat_n, stat_nerr, exp_n, exp_nerr);
        end
    endtask

    task automatic test_clamp();
        bit ok, ok2;
        logic [W:0] s, e; logic [W+1:0] er;
        logic [W-1:0] a, b;
        int k, m;
        longint rs;
        send(16'h0003, 16'h0001, 31, 1, ok);
        recv(ok2, s, e, er);
        checks++;
        if (!(ok && ok2) || s !== 17'h03FFF || er !== 18'd16379) begin
            errors++; $display("FAIL clamp_k31 got ok=%b%b s=%h er=%h want 03fff %h", ok, ok2, s, er, 18'd16379);
        end
        model_stat(16379);
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom);
            k = $urandom_range(31, 15); m = 1 + (i % 2);
            rs = ref_sum(a, b, AMAX, m);
            send(a, b, k, m, ok);
            recv(ok2, s, e, er);
            checks++;
            if (!(ok && ok2) || s !== (W+1)'(rs) || e !== (W+1)'(a + 0 + longint'(b))) begin
                errors++; $display("FAIL clamp_rand a=%h b=%h k=%0d m=%0d got s=%h e=%h want %h",
                                   a, b, k, m, s, e, (W+1)'(rs));
            end
            model_stat(rs - (longint'(a) + longint'(b)));
        end
        @(negedge clk);
    endtask

    task automatic test_stream(input int rdy_pct, input int n);
        exp_t q[$];
        exp_t x;
        int sent = 0, got = 0, cyc = 0, first_acc = -1;
        bit stalled = 0, first_seen = 0;
        logic [W-1:0] a, b;
        int k, m;
        longint rs;
        @(negedge clk);
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        model_clr();
        a = W'($urandom); b = W'($urandom); k = $urandom_range(31); m = $urandom_range(3);
        while ((sent < n || got < n) && cyc < 400) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            if (sent < n && (rdy_pct == 100 || $urandom_range(3) != 0)) begin
                bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
                bus.cfg_k = KW'(k); bus.cfg_mode = 2'(m);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                checks++;
                if (!bus.out_valid) begin errors++; $display("FAIL stream_stall_drop cyc=%0d got valid 0 want 1", cyc); end
            end
            if (rdy_pct == 100) begin
                checks++;
                if (!bus.in_ready) begin errors++; $display("FAIL stream_in_ready cyc=%0d got 0 want 1", cyc); end
            end
            if (bus.out_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    checks++;
                    if (cyc - first_acc != 2) begin
                        errors++; $display("FAIL stream_latency got %0d want 2", cyc - first_acc);
                    end
                end
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra got s=%h want no result", bus.out_sum);
                end else if (bus.out_sum !== q[0].s || bus.out_exact !== q[0].e || bus.out_err !== q[0].er) begin
                    errors++; $display("FAIL stream_data cyc=%0d got s=%h e=%h er=%h want %h %h %h",
                                       cyc, bus.out_sum, bus.out_exact, bus.out_err, q[0].s, q[0].e, q[0].er);
                end
                if (bus.out_ready && q.size() != 0) begin
                    model_stat(q[0].err);
                    void'(q.pop_front());
                    got++;
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            if (bus.in_valid && bus.in_ready) begin
                rs    = ref_sum(a, b, k, m);
                x.s   = (W+1)'(rs);
                x.e   = (W+1)'(longint'(a) + longint'(b));
                x.err = rs - (longint'(a) + longint'(b));
                x.er  = (W+2)'(x.err);
                q.push_back(x);
                if (first_acc < 0) first_acc = cyc;
                sent++;
                a = W'($urandom); b = W'($urandom); k = $urandom_range(31); m = $urandom_range(3);
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != n || q.size() != 0) begin
            errors++; $display("FAIL stream_count got %0d left %0d want %0d", got, q.size(), n);
        end
        if (rdy_pct == 100) begin
            checks++;
            if (cyc != n + 2) begin errors++; $display("FAIL stream_throughput got %0d cycles want %0d", cyc, n + 2); end
        end
        @(negedge clk);
        checks++;
        if (stat_n !== CW'(n) || stat_nerr !== CW'(exp_nerr) || stat_maxabs !== (W+1)'(exp_maxabs) ||
            stat_sumabs !== CW'(exp_sumabs)) begin
            errors++; $display("FAIL stream_stats got n=%0d nerr=%0d max=%0d sum=%0d want %0d %0d %0d %0d",
                               stat_n, stat_nerr, stat_maxabs, stat_sumabs, n, exp_nerr, exp_maxabs, exp_sumabs);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_stat_clr();
        bit ok, ok2;
        int t = 0;
        logic [W:0] s, e; logic [W+1:0] er;
        bus.out_ready = 1'b1;
        send(16'h0003, 16'h0001, 14, 1, ok);
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (!(ok && bus.out_valid)) begin errors++; $display("FAIL clr_setup got ok=%b valid=%b want 1 1", ok, bus.out_valid); end
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        model_clr();
        @(negedge clk);
        checks++;
        if (stat_n !== '0 || stat_nerr !== '0 || stat_maxabs !== '0 || stat_sumabs !== '0) begin
            errors++; $display("FAIL clr_coincident got n=%0d nerr=%0d max=%0d sum=%0d want 0",
                               stat_n, stat_nerr, stat_maxabs, stat_sumabs);
        end
        send(16'h000F, 16'h0001, 4, 2, ok);
        recv(ok2, s, e, er);
        model_stat(-1);
        @(negedge clk);
        checks++;
        if (stat_n !== CW'(exp_n) || stat_sumabs !== CW'(exp_sumabs)) begin
            errors++; $display("FAIL clr_recount got n=%0d sum=%0d want %0d %0d", stat_n, stat_sumabs, exp_n, exp_sumabs);
        end
    endtask

    task automatic test_rst_midflight();
        bit ok, ok2;
        int stale = 0;
        logic [W:0] s, e; logic [W+1:0] er;
        bus.out_ready = 1'b0;
        send(16'h1111, 16'h2222, 0, 0, ok);
        send(16'h3333, 16'h4444, 0, 0, ok2);
        @(negedge clk);
        checks++;
        if (!(ok && ok2 && bus.out_valid)) begin
            errors++; $display("FAIL rst_setup got ok=%b%b valid=%b want 1 1 1", ok, ok2, bus.out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clr();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || stat_n !== '0) begin
            errors++; $display("FAIL rst_flush got valid=%b n=%0d want 0 0", bus.out_valid, stat_n);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rst_stale got %0d stale results want 0", stale); end
        send(16'h0100, 16'h0023, 3, 2, ok);
        recv(ok2, s, e, er);
        checks++;
        if (!(ok && ok2) || s !== 17'h00123 || er !== '0) begin
            errors++; $display("FAIL rst_after got ok=%b%b s=%h er=%h want 00123 0", ok, ok2, s, er);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.cfg_k = '0; bus.cfg_mode = '0; bus.out_ready = 1'b0;
        test_reset();
        test_mode1();
        test_mode2_and_exact();
        test_clamp();
        test_stream(100, 8);
        test_stream(50, 8);
        test_stat_clr();
        test_rst_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
